// File: rtl/sram_rw_port_initiator.sv
// -----------------------------------------------------------------------------
// sram_rw_port_initiator
//
// This is the initiator-side controller for a single-port (1RW) OpenRAM macro
// wrapper that uses the RW0_* interface.
//   - It turns a valid/ready request stream into RW0 port cycles.
//   - It returns read data, in request order, on a backpressured response stream.
//   - After reset it sweeps the whole array and writes zeros, unless
//     INIT_ENABLE=0.
//
// Ports
//   clock, reset_n        single clock; asynchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_write             1 = write, 0 = read
//   req_addr              word address
//   req_wdata             write data
//   req_wmask             per-lane write enable
//   resp_valid/resp_ready response handshake
//   resp_rdata            read data, returned in request order
//   init_done             high once the zero-fill sweep has finished
//   RW0_*                 macro port; RW0_rdata is valid the cycle after a read edge
// -----------------------------------------------------------------------------
module sram_rw_port_initiator #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 88,
  parameter int MASK_W      = 4,
  parameter int RESP_DEPTH  = 2,
  parameter int INIT_ENABLE = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_done,
  output logic              RW0_clk,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic [DATA_W-1:0] RW0_wdata,
  output logic [MASK_W-1:0] RW0_wmask,
  input  logic [DATA_W-1:0] RW0_rdata
);

  localparam int PTR_W = $clog2(RESP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {S_INIT, S_RUN} state_t;
  localparam state_t RESET_STATE = (INIT_ENABLE != 0) ? S_INIT : S_RUN;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_init_addr;
  logic                r_init_done;
  logic                r_rd_pend;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [DATA_W-1:0]   r_fifo_mem [RESP_DEPTH];

  logic                w_req_ready;
  logic                w_acc;
  logic                w_en;
  logic                w_wmode;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic [MASK_W-1:0]   w_wmask;
  logic                w_push;
  logic                w_pop;
  logic [CNT_W:0]      w_occ;
  logic                w_space;

  assign w_pop  = resp_valid & resp_ready;
  assign w_push = r_rd_pend;

  // A read is accepted only when a FIFO slot is available for its data.
  // A read still in flight in the macro also occupies a slot. A slot being
  // popped in this same cycle counts as free.
  assign w_occ   = {1'b0, r_count} + {{CNT_W{1'b0}}, r_rd_pend} - {{CNT_W{1'b0}}, w_pop};
  assign w_space = w_occ < (CNT_W + 1)'(RESP_DEPTH);

  // NOTE: every signal gets a default before the case statement, so no path can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    w_acc       = 1'b0;
    w_en        = 1'b0;
    w_wmode     = 1'b0;
    w_addr      = req_addr;
    w_wdata     = req_wdata;
    w_wmask     = req_wmask;
    case (r_state)
      S_INIT: begin
        w_en    = 1'b1;
        w_wmode = 1'b1;
        w_addr  = r_init_addr;
        w_wdata = '0;
        w_wmask = '1;
        if (r_init_addr == LAST_ADDR) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_req_ready = req_write | w_space;
        w_acc       = req_valid & w_req_ready;
        w_en        = w_acc;
        w_wmode     = w_acc & req_write;
      end
      default: w_state_nxt = RESET_STATE;
    endcase
    // The port stays quiet and no request is taken while reset is held.
    if (!reset_n) begin
      w_req_ready = 1'b0;
      w_acc       = 1'b0;
      w_en        = 1'b0;
      w_wmode     = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= RESET_STATE;
      r_init_addr <= '0;
      r_init_done <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT) r_init_addr <= r_init_addr + 1'b1;
      // init_done goes high at the same edge that enters RUN.
      if (w_state_nxt == S_RUN) r_init_done <= 1'b1;
      r_rd_pend <= w_acc & ~req_write;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // NOTE: the FIFO storage has no reset. r_count controls visibility, so stale entries are never presented.
  always_ff @(posedge clock) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= RW0_rdata;
  end

  assign req_ready  = w_req_ready;
  assign resp_valid = (r_count != '0);
  assign resp_rdata = r_fifo_mem[r_rd_ptr];
  assign init_done  = r_init_done;

  assign RW0_clk   = clock;
  assign RW0_en    = w_en;
  assign RW0_wmode = w_wmode;
  assign RW0_addr  = w_addr;
  assign RW0_wdata = w_wdata;
  assign RW0_wmask = w_wmask;

endmodule
